// File: rtl/board_io_pins_if.sv
// board_io_pins_if: SoC/pin-side signal bundle for board_io_pins.
interface board_io_pins_if #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int NDIGITS = 8
);
    logic [IN_W-1:0]      pins_in;
    logic [IN_W-1:0]      gpio_in;
    logic [IN_W-1:0]      gpio_in_rise;
    logic [OUT_W-1:0]     gpio_out;
    logic [OUT_W-1:0]     pins_out;
    logic [NDIGITS*8-1:0] seg_in;
    logic                 seg_mode;
    logic [NDIGITS*8-1:0] pins_seg_par;
    logic [7:0]           pins_seg;
    logic [NDIGITS-1:0]   pins_an;
    modport master (
        output pins_in, gpio_out, seg_in, seg_mode,
        input  gpio_in, gpio_in_rise, pins_out, pins_seg_par, pins_seg, pins_an
    );
    modport slave (
        input  pins_in, gpio_out, seg_in, seg_mode,
        output gpio_in, gpio_in_rise, pins_out, pins_seg_par, pins_seg, pins_an
    );
endinterface

// File: rtl/board_io_pins.sv
// board_io_pins: debounced inputs with rise pulses, registered LEDs, parallel or scanned seven-segment drive.
module board_io_pins #(
    parameter int IN_W         = 16,
    parameter int OUT_W        = 16,
    parameter int NDIGITS      = 8,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int SCAN_CYC     = 5000
) (
    input logic            clock,
    input logic            reset,
    board_io_pins_if.slave io
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int PW = $clog2(SCAN_CYC);
    localparam int IW = $clog2(NDIGITS);
    logic [IN_W-1:0]      s1_q, s2_q, gpio_q, gpio_d, rise_q, rise_d;
    logic [CW-1:0]        cnt_q [IN_W];
    logic [CW-1:0]        cnt_d [IN_W];
    logic [OUT_W-1:0]     pout_q;
    logic [NDIGITS*8-1:0] par_q, par_d;
    logic [7:0]           seg_q, seg_d;
    logic [NDIGITS-1:0]   an_q, an_d;
    logic [PW-1:0]        psc_q, psc_d;
    logic [IW-1:0]        idx_q, idx_d;

    always_comb begin
        gpio_d = gpio_q;
        rise_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < IN_W; i++) begin
            cnt_d[i]  = (s2_q[i] == gpio_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) ? '0 : cnt_q[i] + CW'(1);
            gpio_d[i] = (s2_q[i] != gpio_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) ? s2_q[i] : gpio_q[i];
            rise_d[i] = gpio_d[i] & ~gpio_q[i];
        end
    end

    // Prescaler value 0 is the blanking slot that separates consecutive digits.
    always_comb begin
        psc_d = '0;
        idx_d = '0;
        an_d  = '1;
        seg_d = 8'hFF;
        par_d = io.seg_in;
        if (io.seg_mode) begin
            par_d = '1;
            psc_d = (psc_q == PW'(SCAN_CYC - 1)) ? '0 : psc_q + PW'(1);
            idx_d = (psc_q != PW'(SCAN_CYC - 1)) ? idx_q : (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
            if (psc_q != '0) begin
                an_d  = ~(NDIGITS'(1) << idx_q);
                seg_d = io.seg_in[{idx_q, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            gpio_q <= '0;
            rise_q <= '0;
            cnt_q  <= '{default: '0};
            pout_q <= '0;
            par_q  <= '1;
            seg_q  <= 8'hFF;
            an_q   <= '1;
            psc_q  <= '0;
            idx_q  <= '0;
        end else begin
            s1_q   <= io.pins_in;
            s2_q   <= s1_q;
            gpio_q <= gpio_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
            pout_q <= io.gpio_out;
            par_q  <= par_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            psc_q  <= psc_d;
            idx_q  <= idx_d;
        end
    end

    assign io.gpio_in      = gpio_q;
    assign io.gpio_in_rise = rise_q;
    assign io.pins_out     = pout_q;
    assign io.pins_seg_par = par_q;
    assign io.pins_seg     = seg_q;
    assign io.pins_an      = an_q;
endmodule

// File: tb/tb_board_io_pins.sv
// tb_board_io_pins: randomized scoreboard bench; driver predicts each cycle's outputs, monitor compares.
module tb_board_io_pins;
    localparam int IN_W = 4, OUT_W = 16, ND = 4, DEB = 4, SCAN = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_io_pins_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NDIGITS(ND)) io ();
    board_io_pins #(.IN_W(IN_W), .OUT_W(OUT_W), .NDIGITS(ND), .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN)) dut (
        .clock(clk),
        .reset(rst),
        .io(io)
    );

    typedef struct {
        logic [3:0]  gin;
        logic [3:0]  rise;
        logic [15:0] pout;
        logic [31:0] par;
        logic [7:0]  seg;
        logic [3:0]  an;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    logic [3:0] acc = '0, h1 = '0, h2 = '0;
    int run[4] = '{0, 0, 0, 0};
    int k = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Model: accept a level after DEB consecutive mismatching synchronised samples; scan position from cycles since scan start.
    task automatic drive(bit r, logic [3:0] p, logic [15:0] go, logic [31:0] s, bit m);
        exp_t e;
        int d;
        rst = r; io.pins_in = p; io.gpio_out = go; io.seg_in = s; io.seg_mode = m;
        e.rise = '0; e.par = '1; e.seg = 8'hFF; e.an = '1; e.pout = '0;
        if (r) begin
            acc = '0; h1 = '0; h2 = '0; k = 0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (h2[i] != acc[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        acc[i] = h2[i];
                        run[i] = 0;
                        e.rise[i] = acc[i];
                    end
                end else run[i] = 0;
            end
            h2 = h1; h1 = p;
            e.pout = go;
            if (!m) begin
                e.par = s;
                k = 0;
            end else begin
                if (k % SCAN != 0) begin
                    d = (k / SCAN) % ND;
                    e.an = ~(4'b0001 << d);
                    e.seg = s[8*d +: 8];
                end
                k++;
            end
        end
        e.gin = acc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("gpio_in", 32'(io.gpio_in), 32'(e.gin));
            check("gpio_in_rise", 32'(io.gpio_in_rise), 32'(e.rise));
            check("pins_out", 32'(io.pins_out), 32'(e.pout));
            check("pins_seg_par", io.pins_seg_par, e.par);
            check("pins_seg", 32'(io.pins_seg), 32'(e.seg));
            check("pins_an", 32'(io.pins_an), 32'(e.an));
        end
    end

    initial begin
        logic [3:0]  p;
        logic [31:0] s;
        bit          m;
        repeat (3) drive(1'b1, 4'($urandom), 16'($urandom), $urandom, 1'($urandom));
        repeat (8) drive(1'b0, 4'h0, 16'($urandom), $urandom, 1'b0);
        repeat (10) drive(1'b0, 4'b0101, 16'($urandom), $urandom, 1'b0);
        repeat (8) drive(1'b0, 4'h0, 16'($urandom), $urandom, 1'b0);
        repeat (3) drive(1'b0, 4'b0001, 16'($urandom), $urandom, 1'b0);
        repeat (8) drive(1'b0, 4'h0, 16'($urandom), $urandom, 1'b0);
        s = $urandom;
        s[23:16] = 8'hC0;
        drive(1'b0, 4'h0, 16'hA5A5, s, 1'b0);
        repeat (26) drive(1'b0, 4'h0, 16'($urandom), 32'h44332211, 1'b1);
        drive(1'b0, 4'h0, 16'($urandom), 32'h44332211, 1'b0);
        repeat (8) drive(1'b0, 4'h0, 16'($urandom), 32'h44332211, 1'b1);
        drive(1'b0, 4'h0, 16'($urandom), 32'h44332211, 1'b0);
        repeat (7) drive(1'b0, 4'h0, 16'($urandom), 32'h44332211, 1'b1);
        p = '0;
        m = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) p[i] = ~p[i];
            if ($urandom_range(0, 39) == 0) m = ~m;
            drive($urandom_range(0, 299) == 0, p, 16'($urandom), $urandom, m);
        end
        @(posedge clk);
        #3;
        check("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board_io_pins.md
Name: board_io_pins

Overview:
- Parametrised board-side pin block that sits between the SoC's GPIO/segment interface and the physical top-level pins.
- Inputs: synchronises and debounces the raw switch/button pins, and flags rising edges.
- Outputs: registers the LED outputs. Drives the seven-segment display either as per-digit parallel buses or as one time-multiplexed scanned bus with digit selects, so boards with fewer pins are supported.

Parameters:
- IN_W, 16, number of raw input pins (switches/buttons).
- OUT_W, 16, number of LED output pins.
- NDIGITS, 8, number of seven-segment digits (>=2).
- DEBOUNCE_CYC, 1000, consecutive stable cycles required before an input change is accepted (>=1).
- SCAN_CYC, 5000, clock cycles each digit is shown in scanned mode (>=2).

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- pins_in  in  IN_W  raw asynchronous input pins.
- gpio_in  out  IN_W  debounced input level to SoC.
- gpio_in_rise  out  IN_W  one-cycle pulse per bit on an accepted 0->1 change.
- gpio_out  in  OUT_W  LED value from SoC.
- pins_out  out  OUT_W  registered LED pins.
- seg_in  in  NDIGITS*8  segment bytes from SoC, active-low; digit k = bits [8k+7:8k].
- seg_mode  in  1  0 = parallel, 1 = scanned.
- pins_seg_par  out  NDIGITS*8  parallel segment pins, active-low.
- pins_seg  out  8  scanned segment bus, active-low.
- pins_an  out  NDIGITS  scanned digit select, active-low one-hot.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on the rising clock edge. Reset overrides all other activity in the same cycle, including mid-debounce and mid-scan.

Reset values:
- gpio_in = 0, gpio_in_rise = 0, pins_out = 0.
- pins_seg_par = all 1s, pins_seg = 8'hFF, pins_an = all 1s (display blank).
- Synchroniser flops = 0, debounce counters = 0, scan prescaler = 0, digit index = 0.

Input path (independent per bit i):
- Two-flop synchroniser: s1 <= pins_in[i], s2 <= s1.
- Per-bit counter cnt, width clog2(DEBOUNCE_CYC+1).
- If s2 == gpio_in[i]: cnt <= 0.
- Else if cnt == DEBOUNCE_CYC-1: gpio_in[i] <= s2, cnt <= 0.
- Else: cnt <= cnt+1.
- Latency: an accepted level appears on gpio_in 2+DEBOUNCE_CYC cycles after pins_in changes.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYC cycles at s2 is rejected; the counter restarts from 0 on any return to the accepted level.
- gpio_in_rise[i] = 1 for exactly the cycle in which gpio_in[i] is first 1 after being 0. Falling changes produce no pulse.

Output path:
- pins_out <= gpio_out every cycle; latency 1.

Segment path, seg_mode = 0:
- pins_seg_par <= seg_in every cycle; latency 1.
- pins_an = all 1s, pins_seg = 8'hFF.
- Scan prescaler and digit index held at 0.

Segment path, seg_mode = 1:
- pins_seg_par = all 1s.
- Prescaler counts 0..SCAN_CYC-1. At terminal count it wraps to 0 and the digit index advances idx = (idx+1) mod NDIGITS; NDIGITS-1 wraps to 0.
- Registered outputs are derived from the pre-edge prescaler and index values:
  - prescaler == 0: pins_an = all 1s and pins_seg = 8'hFF (one-cycle blanking to prevent ghosting).
  - otherwise: pins_an = ~(1<<idx) and pins_seg = seg_in digit idx.
- seg_in is sampled every cycle, so a change shows on the active digit after 1 cycle.

Mode switching:
- On a 1->0 transition the counters reset to 0 on that edge, and the next cycle shows parallel outputs.
- On a 0->1 transition scanning starts at digit 0 with a blank cycle.
- pins_an is never more than one-hot-low.

Test Plan:
- Reset: assert reset for 3 cycles with all inputs random -> every output at its reset value; on the first edge after release gpio_in = 0 and pins_an = 16'hFFFF-style all 1s.
- Debounce accept (IN_W=4, DEBOUNCE_CYC=4): pins_in 0->4'b0101 held -> gpio_in = 4'b0101 exactly 6 cycles later; gpio_in_rise = 4'b0101 for exactly 1 cycle, then 0.
- Glitch reject (DEBOUNCE_CYC=4): pins_in[0] high for 3 cycles, then low -> gpio_in[0] stays 0 and gpio_in_rise stays 0 throughout.
- Parallel path: gpio_out = 16'hA5A5 and seg_in digit 2 = 8'hC0 with seg_mode=0 -> next cycle pins_out = 16'hA5A5, pins_seg_par[23:16] = 8'hC0, pins_an all 1s.
- Scan (NDIGITS=4, SCAN_CYC=3, seg_in = {8'h44,8'h33,8'h22,8'h11}, seg_mode=1):
  - Required per-3-cycle slot pattern: (an=F, seg=FF), (E,11), (E,11), then (F,FF), (D,22), (D,22), then digits 2 and 3 (B and 7 selects).
  - After digit 3 the sequence returns to digit 0 (E,11).
- Mode switch mid-scan: set seg_mode 1->0 while digit 2 is active -> next cycle pins_an = F and pins_seg_par = seg_in; set back to 1 -> scanning restarts with a blank cycle, then digit 0.
